enm_path_ctrl: RTL and testbench

Parametrised enemy controller for N enemy channels.
- Each enemy follows a three-leg path selected by its HP band: vertical, then horizontal, then vertical.
- Adds per-channel configurable start and target coordinates, bidirectional stepping, staggered spawning, monotonic phases, one-cycle kill events and an all-clear flag.
- Sits between the HP/collision logic and the VGA sprite renderer, running on clk22.

---
 rtl/enm_path_ctrl.sv | 172 +++++++++++++++++
 tb/tb_enm_path_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/enm_path_ctrl.sv
// enm_path_ctrl -- enemy path controller for N_ENM independent channels.
//
// Each channel spawns in turn (staggered by SPAWN_GAP ticks), then walks a
// three-leg path (vertical to cfg_y1, horizontal to cfg_x1, vertical to
// cfg_y2). Its HP band selects the leg. Phases only ever move forward.
// HP of zero kills the channel until the next rst/gamestart.
//
// Ports:
//   clk22       game tick clock
//   rst         synchronous active-high reset
//   gamestart   synchronous restart, same effect as rst
//   enmhp       HP per channel, channel i at [i*HPW +: HPW]
//   cfg_x0/y0   start position per channel (loaded on reset)
//   cfg_y1      phase-1 target y
//   cfg_x1      phase-2 target x
//   cfg_y2      phase-3 target y
//   alive       channel in P1/P2/P3
//   phase       2 bits per channel: 0 inactive, 1/2/3 path phase
//   enmx/enmy   current position per channel
//   kill_pulse  one-cycle pulse when a live channel dies
//   all_clear   every channel DEAD
module enm_path_ctrl #(
    parameter int N_ENM     = 4,
    parameter int HPW       = 7,
    parameter int CW        = 10,
    parameter int HP_HI     = 80,
    parameter int HP_LO     = 40,
    parameter int STEP_X    = 1,
    parameter int STEP_Y    = 2,
    parameter int SPAWN_GAP = 32
) (
    input  logic                  clk22,
    input  logic                  rst,
    input  logic                  gamestart,
    input  logic [N_ENM*HPW-1:0]  enmhp,
    input  logic [N_ENM*CW-1:0]   cfg_x0,
    input  logic [N_ENM*CW-1:0]   cfg_y0,
    input  logic [N_ENM*CW-1:0]   cfg_y1,
    input  logic [N_ENM*CW-1:0]   cfg_x1,
    input  logic [N_ENM*CW-1:0]   cfg_y2,
    output logic [N_ENM-1:0]      alive,
    output logic [2*N_ENM-1:0]    phase,
    output logic [N_ENM*CW-1:0]   enmx,
    output logic [N_ENM*CW-1:0]   enmy,
    output logic [N_ENM-1:0]      kill_pulse,
    output logic                  all_clear
);

    // Encoding order matters: the live next state is max(current, band),
    // and DEAD sits above every path phase so hp==0 always wins.
    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_DEAD = 3'd4
    } state_t;

    localparam int unsigned CNT_MAX = (N_ENM - 1) * SPAWN_GAP;
    localparam int          CNTW    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [HPW-1:0] HP_HI_V  = HPW'(HP_HI);
    localparam logic [HPW-1:0] HP_LO_V  = HPW'(HP_LO);
    localparam logic [CW-1:0]  STEP_X_V = CW'(STEP_X);
    localparam logic [CW-1:0]  STEP_Y_V = CW'(STEP_Y);

    logic            w_restart;
    logic [CNTW-1:0] r_cnt;
    logic [N_ENM-1:0] w_dead;

    assign w_restart = rst | gamestart;

    // Spawn counter saturates once the last channel's threshold is reached.
    always_ff @(posedge clk22) begin
        if (w_restart)
            r_cnt <= '0;
        else if (32'(r_cnt) < CNT_MAX)
            r_cnt <= r_cnt + CNTW'(1);
    end

    // Move pos toward tgt by at most step. Magnitude is compared before any
    // subtraction, so the result never wraps and lands exactly on target.
    function automatic logic [CW-1:0] f_step(input logic [CW-1:0] pos,
                                             input logic [CW-1:0] tgt,
                                             input logic [CW-1:0] step);
        logic [CW-1:0] v;
        if (pos < tgt)
            v = ((tgt - pos) <= step) ? tgt : pos + step;
        else
            v = ((pos - tgt) <= step) ? tgt : pos - step;
        return v;
    endfunction

    for (genvar i = 0; i < N_ENM; i++) begin : g_ch
        localparam int unsigned SPAWN_TH = i * SPAWN_GAP;

        state_t          r_st, w_nst, w_band;
        logic [CW-1:0]   r_x, r_y, w_nx, w_ny;
        logic            r_kill;
        logic [HPW-1:0]  w_hp;
        logic            w_spawn, w_alive;
        logic [1:0]      w_phase;

        assign w_hp    = enmhp[i*HPW +: HPW];
        assign w_spawn = (32'(r_cnt) >= SPAWN_TH);

        always_comb begin
            if (w_hp > HP_HI_V)       w_band = S_P1;
            else if (w_hp > HP_LO_V)  w_band = S_P2;
            else if (w_hp != '0)      w_band = S_P3;
            else                      w_band = S_DEAD;
        end

        // Next-state logic
        always_comb begin
            w_nst = r_st;
            case (r_st)
                S_WAIT:  if (w_spawn) w_nst = w_band;
                S_DEAD:  w_nst = S_DEAD;
                default: w_nst = (w_band > r_st) ? w_band : r_st;
            endcase
        end

        // Movement follows the state being entered on this edge.
        always_comb begin
            w_nx = r_x;
            w_ny = r_y;
            case (w_nst)
                S_P1:    w_ny = f_step(r_y, cfg_y1[i*CW +: CW], STEP_Y_V);
                S_P2:    w_nx = f_step(r_x, cfg_x1[i*CW +: CW], STEP_X_V);
                S_P3:    w_ny = f_step(r_y, cfg_y2[i*CW +: CW], STEP_Y_V);
                S_DEAD: begin
                    w_nx = '0;
                    w_ny = '0;
                end
                default: ;
            endcase
        end

        // State register
        always_ff @(posedge clk22) begin
            if (w_restart) begin
                r_st   <= S_WAIT;
                r_x    <= cfg_x0[i*CW +: CW];
                r_y    <= cfg_y0[i*CW +: CW];
                r_kill <= 1'b0;
            end else begin
                r_st   <= w_nst;
                r_x    <= w_nx;
                r_y    <= w_ny;
                // Only a live channel dying pulses; WAIT->DEAD is silent.
                r_kill <= (r_st inside {S_P1, S_P2, S_P3}) && (w_nst == S_DEAD);
            end
        end

        // Outputs
        always_comb begin
            w_alive = r_st inside {S_P1, S_P2, S_P3};
            w_phase = w_alive ? r_st[1:0] : 2'd0;
        end

        assign alive[i]             = w_alive;
        assign phase[2*i +: 2]      = w_phase;
        assign enmx[i*CW +: CW]     = r_x;
        assign enmy[i*CW +: CW]     = r_y;
        assign kill_pulse[i]        = r_kill;
        assign w_dead[i]            = (r_st == S_DEAD);
    end

    assign all_clear = &w_dead;

endmodule

// File: tb/tb_enm_path_ctrl.sv
module tb_enm_path_ctrl;
    localparam int N     = 4;
    localparam int HPW   = 7;
    localparam int CW    = 10;
    localparam int HP_HI = 80;
    localparam int HP_LO = 40;
    localparam int SX    = 1;
    localparam int SY    = 2;
    localparam int GAP   = 32;

    logic clk22 = 1'b0;
    always #5 clk22 = ~clk22;

    logic              rst = 1'b1, gamestart = 1'b0;
    logic [N*HPW-1:0]  enmhp = '0;
    logic [N*CW-1:0]   cfg_x0 = '0, cfg_y0 = '0, cfg_y1 = '0, cfg_x1 = '0, cfg_y2 = '0;
    logic [N-1:0]      alive, kill_pulse;
    logic [2*N-1:0]    phase;
    logic [N*CW-1:0]   enmx, enmy;
    logic              all_clear;

    enm_path_ctrl #(.N_ENM(N), .HPW(HPW), .CW(CW), .HP_HI(HP_HI), .HP_LO(HP_LO),
                    .STEP_X(SX), .STEP_Y(SY), .SPAWN_GAP(GAP)) dut (
        .clk22(clk22), .rst(rst), .gamestart(gamestart), .enmhp(enmhp),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1), .cfg_x1(cfg_x1), .cfg_y2(cfg_y2),
        .alive(alive), .phase(phase), .enmx(enmx), .enmy(enmy),
        .kill_pulse(kill_pulse), .all_clear(all_clear));

    typedef struct {
        logic [N-1:0]    alive;
        logic [2*N-1:0]  phase;
        logic [N*CW-1:0] x, y;
        logic [N-1:0]    kill;
        logic            ac;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int errors = 0, checks = 0;

    // Reference model: phase 0 = waiting, 1..3 = path leg, 4 = dead.
    int m_st[N], m_x[N], m_y[N], m_cnt;
    bit m_kill[N];
    int hp[N], cx0[N], cy0[N], cy1[N], cx1[N], cy2[N];

    function automatic int band(input int h);
        if (h > HP_HI) return 1;
        if (h > HP_LO) return 2;
        if (h > 0)     return 3;
        return 4;
    endfunction

    function automatic int stepto(input int p, input int t, input int s);
        if (p < t) return (t - p <= s) ? t : p + s;
        return (p - t <= s) ? t : p - s;
    endfunction

    task automatic model_edge(input bit restart);
        int ns;
        if (restart) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_x[i] = cx0[i]; m_y[i] = cy0[i]; m_kill[i] = 0;
            end
            m_cnt = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            ns = m_st[i];
            if (m_st[i] == 0) begin
                if (m_cnt >= i * GAP) ns = band(hp[i]);
            end else if (m_st[i] != 4) begin
                ns = (band(hp[i]) > m_st[i]) ? band(hp[i]) : m_st[i];
            end
            m_kill[i] = (m_st[i] >= 1 && m_st[i] <= 3 && ns == 4);
            case (ns)
                1: m_y[i] = stepto(m_y[i], cy1[i], SY);
                2: m_x[i] = stepto(m_x[i], cx1[i], SX);
                3: m_y[i] = stepto(m_y[i], cy2[i], SY);
                4: begin m_x[i] = 0; m_y[i] = 0; end
                default: ;
            endcase
            m_st[i] = ns;
        end
        if (m_cnt < (N - 1) * GAP) m_cnt++;
    endtask

    task automatic tick(input bit r, input bit g);
        exp_t x;
        @(negedge clk22);
        rst = r; gamestart = g;
        for (int i = 0; i < N; i++) begin
            enmhp[i*HPW +: HPW] = HPW'(hp[i]);
            cfg_x0[i*CW +: CW]  = CW'(cx0[i]);
            cfg_y0[i*CW +: CW]  = CW'(cy0[i]);
            cfg_y1[i*CW +: CW]  = CW'(cy1[i]);
            cfg_x1[i*CW +: CW]  = CW'(cx1[i]);
            cfg_y2[i*CW +: CW]  = CW'(cy2[i]);
        end
        model_edge(r | g);
        x.ac = 1'b1;
        for (int i = 0; i < N; i++) begin
            x.alive[i]       = (m_st[i] >= 1 && m_st[i] <= 3);
            x.phase[2*i +: 2] = x.alive[i] ? 2'(m_st[i]) : 2'd0;
            x.x[i*CW +: CW]  = CW'(m_x[i]);
            x.y[i*CW +: CW]  = CW'(m_y[i]);
            x.kill[i]        = m_kill[i];
            if (m_st[i] != 4) x.ac = 1'b0;
        end
        q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every edge presents a new output set; compare against the
    // oldest pending expectation.
    always @(posedge clk22) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("alive",     64'(alive),      64'(e.alive));
            chk("phase",     64'(phase),      64'(e.phase));
            chk("enmx",      64'(enmx),       64'(e.x));
            chk("enmy",      64'(enmy),       64'(e.y));
            chk("kill",      64'(kill_pulse), 64'(e.kill));
            chk("all_clear", 64'(all_clear),  64'(e.ac));
        end
    end

    function automatic int rand_hp();
        case ($urandom_range(7))
            0: return 0;
            1: return 40;
            2: return 41;
            3: return 80;
            4: return 81;
            5: return 127;
            default: return int'($urandom_range(127, 1));
        endcase
    endfunction

    task automatic rand_cfg();
        for (int i = 0; i < N; i++) begin
            cx0[i] = $urandom_range(1023); cy0[i] = $urandom_range(1023);
            cy1[i] = $urandom_range(1023); cx1[i] = $urandom_range(1023);
            cy2[i] = $urandom_range(1023);
        end
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        rand_cfg();
        // Directed path on channel 0: climb, traverse, descend, then die.
        cx0[0] = 40; cy0[0] = 40; cy1[0] = 220; cx1[0] = 120; cy2[0] = 40;
        for (int i = 0; i < N; i++) hp[i] = 100;
        tick(1, 0);
        repeat (100) tick(0, 0);
        hp[0] = 60;  repeat (90) tick(0, 0);
        hp[0] = 100; repeat (10) tick(0, 0);
        hp[0] = 30;  hp[2] = 30; repeat (100) tick(0, 0);
        hp[2] = 0;   tick(0, 0);
        hp[2] = 50;  repeat (5) tick(0, 0);
        for (int i = 0; i < N; i++) hp[i] = 0;
        repeat (3) tick(0, 0);

        // Odd distance: 41 -> 43 -> 44, never 45.
        for (int i = 0; i < N; i++) hp[i] = 100;
        cy0[1] = 41; cy1[1] = 44;
        tick(1, 0);
        repeat (40) tick(0, 0);
        // Restart mid-P2, then observe the respawn sequence again.
        for (int i = 0; i < N; i++) hp[i] = 60;
        repeat (60) tick(0, 0);
        tick(0, 1);
        repeat (110) tick(0, 0);

        // Randomized segments with occasional mid-path restarts.
        for (int s = 0; s < 8; s++) begin
            rand_cfg();
            for (int i = 0; i < N; i++) hp[i] = rand_hp();
            tick(s[0] == 1'b0, s[0] == 1'b1);
            repeat (350) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(29) == 0) hp[i] = rand_hp();
                tick(1'b0, $urandom_range(399) == 0);
            end
            for (int i = 0; i < N; i++) hp[i] = 0;
            repeat (3) tick(0, 0);
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk22);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
